conv_axil_regfile: RTL and testbench

CONV_AXIL_REGFILE -- requirements
Module: conv_axil_regfile

---
 rtl/conv_axil_regfile.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_conv_axil_regfile.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_axil_regfile.sv
// ---------------------------------------------------------------------------
// conv_axil_regfile
//
// AXI4-Lite slave exposing a small bank of software-visible registers.
// The lower indices are read/write control registers, the top C_NUM_RO
// indices are read-only and return the matching status_in slice.
// Writes and reads run on two independent state machines, so a read can be
// serviced while a write is still waiting for its data or response.
//
// Ports
//   ACLK, ARESETN       single clock, asynchronous active-low reset
//   s_axi_aw*           write address channel (awprot ignored)
//   s_axi_w*            write data channel with byte strobes
//   s_axi_b*            write response channel (OKAY / SLVERR)
//   s_axi_ar*           read address channel (arprot ignored)
//   s_axi_r*            read data channel (OKAY / SLVERR)
//   reg_out             flattened register contents, register k in slice k
//   status_in           values returned for the read-only registers
//   wr_pulse            one-cycle strobe per register on a successful write
// ---------------------------------------------------------------------------
module conv_axil_regfile #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH = 8,
    parameter int C_NUM_REGS   = 4,
    parameter int C_NUM_RO     = 0
) (
    input  logic                                              ACLK,
    input  logic                                              ARESETN,
    input  logic [C_ADDR_WIDTH-1:0]                           s_axi_awaddr,
    input  logic [2:0]                                        s_axi_awprot,
    input  logic                                              s_axi_awvalid,
    output logic                                              s_axi_awready,
    input  logic [C_DATA_WIDTH-1:0]                           s_axi_wdata,
    input  logic [C_DATA_WIDTH/8-1:0]                         s_axi_wstrb,
    input  logic                                              s_axi_wvalid,
    output logic                                              s_axi_wready,
    output logic [1:0]                                        s_axi_bresp,
    output logic                                              s_axi_bvalid,
    input  logic                                              s_axi_bready,
    input  logic [C_ADDR_WIDTH-1:0]                           s_axi_araddr,
    input  logic [2:0]                                        s_axi_arprot,
    input  logic                                              s_axi_arvalid,
    output logic                                              s_axi_arready,
    output logic [C_DATA_WIDTH-1:0]                           s_axi_rdata,
    output logic [1:0]                                        s_axi_rresp,
    output logic                                              s_axi_rvalid,
    input  logic                                              s_axi_rready,
    output logic [C_NUM_REGS*C_DATA_WIDTH-1:0]                reg_out,
    input  logic [((C_NUM_RO > 0) ? C_NUM_RO : 1)*C_DATA_WIDTH-1:0] status_in,
    output logic [C_NUM_REGS-1:0]                             wr_pulse
);

    localparam int STRB_W = C_DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = C_ADDR_WIDTH - LSB;
    localparam int NUM_RW = C_NUM_REGS - C_NUM_RO;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rstate_t;

    wstate_t wstate;
    rstate_t rstate;

    // Captured halves of a write that arrived one channel ahead of the other.
    logic [IDX_W-1:0]        aw_idx_q;
    logic [C_DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]       w_strb_q;

    logic [C_DATA_WIDTH-1:0] regs [C_NUM_REGS];

    // Commit-side signals resolved from whichever source holds each half.
    logic                    aw_hs;
    logic                    w_hs;
    logic                    commit;
    logic [IDX_W-1:0]        c_idx;
    logic [C_DATA_WIDTH-1:0] c_data;
    logic [STRB_W-1:0]       c_strb;
    logic                    c_ok;
    logic [C_NUM_REGS-1:0]   commit_sel;

    // Read-side selection.
    logic                    ar_hs;
    logic [IDX_W-1:0]        r_idx;
    logic [C_DATA_WIDTH-1:0] rd_data;
    logic [1:0]              rd_resp;

    // Protection bits and byte-offset address bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awprot, s_axi_arprot,
                             s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0],
                             status_in};

    function automatic logic idx_is_rw(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} < (IDX_W+1)'(NUM_RW);
    endfunction

    // Work out whether this edge completes a write and, if so, which address
    // and data take part: a half already captured in a register, or the half
    // being handed over on the bus right now.
    always_comb begin
        aw_hs  = s_axi_awvalid & s_axi_awready;
        w_hs   = s_axi_wvalid & s_axi_wready;
        commit = 1'b0;
        c_idx  = aw_idx_q;
        c_data = w_data_q;
        c_strb = w_strb_q;
        case (wstate)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                    c_idx  = s_axi_awaddr[C_ADDR_WIDTH-1:LSB];
                    c_data = s_axi_wdata;
                    c_strb = s_axi_wstrb;
                end
            end
            W_HAVE_AW: begin
                if (w_hs) begin
                    commit = 1'b1;
                    c_data = s_axi_wdata;
                    c_strb = s_axi_wstrb;
                end
            end
            W_HAVE_W: begin
                if (aw_hs) begin
                    commit = 1'b1;
                    c_idx  = s_axi_awaddr[C_ADDR_WIDTH-1:LSB];
                end
            end
            default: begin
                commit = 1'b0;
            end
        endcase
        c_ok = idx_is_rw(c_idx);
        for (int k = 0; k < C_NUM_REGS; k++) begin
            commit_sel[k] = commit && c_ok && ({1'b0, c_idx} == (IDX_W+1)'(k));
        end
    end

    // Write channel state machine. Ready flags are registered so that they
    // stay low through reset and rise on the first clock after release.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wstate        <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            wr_pulse      <= '0;
            aw_idx_q      <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
        end else begin
            wr_pulse <= '0;
            if (commit) begin
                wstate        <= W_RESP;
                s_axi_awready <= 1'b0;
                s_axi_wready  <= 1'b0;
                s_axi_bvalid  <= 1'b1;
                s_axi_bresp   <= c_ok ? RESP_OKAY : RESP_SLVERR;
                wr_pulse      <= commit_sel;
            end else begin
                case (wstate)
                    W_IDLE: begin
                        if (aw_hs) begin
                            aw_idx_q      <= s_axi_awaddr[C_ADDR_WIDTH-1:LSB];
                            wstate        <= W_HAVE_AW;
                            s_axi_awready <= 1'b0;
                            s_axi_wready  <= 1'b1;
                        end else if (w_hs) begin
                            w_data_q      <= s_axi_wdata;
                            w_strb_q      <= s_axi_wstrb;
                            wstate        <= W_HAVE_W;
                            s_axi_awready <= 1'b1;
                            s_axi_wready  <= 1'b0;
                        end else begin
                            s_axi_awready <= 1'b1;
                            s_axi_wready  <= 1'b1;
                        end
                    end
                    W_RESP: begin
                        if (s_axi_bready) begin
                            wstate        <= W_IDLE;
                            s_axi_bvalid  <= 1'b0;
                            s_axi_awready <= 1'b1;
                            s_axi_wready  <= 1'b1;
                        end
                    end
                    default: begin
                        wstate <= wstate;
                    end
                endcase
            end
        end
    end

    // Register storage. Only read/write indices can ever be selected by
    // commit_sel, so the read-only slots keep their reset value.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int k = 0; k < C_NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int k = 0; k < C_NUM_REGS; k++) begin
                if (commit_sel[k]) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (c_strb[b]) begin
                            regs[k][8*b +: 8] <= c_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_reg_out
        assign reg_out[k*C_DATA_WIDTH +: C_DATA_WIDTH] = regs[k];
    end

    // Read data selection. Register values come straight from the flops, so
    // a write committing on the same edge is not yet visible (old data).
    always_comb begin
        ar_hs   = s_axi_arvalid & s_axi_arready;
        r_idx   = s_axi_araddr[C_ADDR_WIDTH-1:LSB];
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        for (int k = 0; k < NUM_RW; k++) begin
            if ({1'b0, r_idx} == (IDX_W+1)'(k)) begin
                rd_data = regs[k];
                rd_resp = RESP_OKAY;
            end
        end
        for (int j = 0; j < C_NUM_RO; j++) begin
            if ({1'b0, r_idx} == (IDX_W+1)'(NUM_RW + j)) begin
                rd_data = status_in[j*C_DATA_WIDTH +: C_DATA_WIDTH];
                rd_resp = RESP_OKAY;
            end
        end
    end

    // Read channel state machine; rdata/rresp are held until rready.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rstate        <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (ar_hs) begin
                        rstate        <= R_RESP;
                        s_axi_arready <= 1'b0;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_rdata   <= rd_data;
                        s_axi_rresp   <= rd_resp;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (s_axi_rready) begin
                        rstate        <= R_IDLE;
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                    end
                end
                default: begin
                    rstate <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_axil_regfile.sv
// ---------------------------------------------------------------------------
// tb_conv_axil_regfile
//
// Drives the register file with directed and randomized AXI4-Lite traffic
// and compares every output against a transaction-level model on each
// falling clock edge. The DUT is built with four registers, the top one
// read-only, so both the read/write and status paths are exercised.
// ---------------------------------------------------------------------------
module tb_conv_axil_regfile;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam int NUM_RW = 3;

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic [7:0]   s_axi_awaddr = '0;
    logic [2:0]   s_axi_awprot = '0;
    logic         s_axi_awvalid = 1'b0;
    logic         s_axi_awready;
    logic [31:0]  s_axi_wdata = '0;
    logic [3:0]   s_axi_wstrb = '0;
    logic         s_axi_wvalid = 1'b0;
    logic         s_axi_wready;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready = 1'b0;
    logic [7:0]   s_axi_araddr = '0;
    logic [2:0]   s_axi_arprot = '0;
    logic         s_axi_arvalid = 1'b0;
    logic         s_axi_arready;
    logic [31:0]  s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rvalid;
    logic         s_axi_rready = 1'b0;
    logic [127:0] reg_out;
    logic [31:0]  status_in = '0;
    logic [3:0]   wr_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    bit rand_done;

    // Model state: what the slave currently holds, in transaction terms.
    bit          m_ready_on;
    bit          m_aw_held;
    bit          m_w_held;
    bit          m_b_pend;
    bit          m_r_pend;
    logic [7:0]  m_aw_addr;
    logic [31:0] m_w_data;
    logic [3:0]  m_w_strb;
    logic [1:0]  m_bresp;
    logic [1:0]  m_rresp;
    logic [31:0] m_rdata;
    logic [3:0]  m_pulse;
    logic [31:0] m_regs [4];

    always #5 ACLK = ~ACLK;

    conv_axil_regfile #(
        .C_DATA_WIDTH (32),
        .C_ADDR_WIDTH (8),
        .C_NUM_REGS   (4),
        .C_NUM_RO     (1)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .reg_out       (reg_out),
        .status_in     (status_in),
        .wr_pulse      (wr_pulse)
    );

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic report_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s actual=timeout required=handshake", name);
    endtask

    // Advance the model by one clock edge. Reads look at the register
    // values before any write finishing on the same edge.
    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            m_ready_on = 0; m_aw_held = 0; m_w_held = 0; m_b_pend = 0; m_r_pend = 0;
            m_pulse = '0; m_bresp = OKAY; m_rresp = OKAY; m_rdata = '0;
            for (int k = 0; k < 4; k++) m_regs[k] = '0;
        end else begin
            bit awr, wr, arr;
            int idx;
            logic [31:0] mask;
            awr = m_ready_on && !m_aw_held && !m_b_pend;
            wr  = m_ready_on && !m_w_held && !m_b_pend;
            arr = m_ready_on && !m_r_pend;

            if (m_r_pend && s_axi_rready) m_r_pend = 0;
            if (s_axi_arvalid && arr) begin
                idx = int'(s_axi_araddr) / 4;
                if (idx < NUM_RW) begin
                    m_rdata = m_regs[idx]; m_rresp = OKAY;
                end else if (idx == 3) begin
                    m_rdata = status_in; m_rresp = OKAY;
                end else begin
                    m_rdata = '0; m_rresp = SLVERR;
                end
                m_r_pend = 1;
            end

            m_pulse = '0;
            if (m_b_pend && s_axi_bready) m_b_pend = 0;
            if (s_axi_awvalid && awr) begin
                m_aw_held = 1; m_aw_addr = s_axi_awaddr;
            end
            if (s_axi_wvalid && wr) begin
                m_w_held = 1; m_w_data = s_axi_wdata; m_w_strb = s_axi_wstrb;
            end
            if (m_aw_held && m_w_held) begin
                idx = int'(m_aw_addr) / 4;
                if (idx < NUM_RW) begin
                    mask = {{8{m_w_strb[3]}}, {8{m_w_strb[2]}}, {8{m_w_strb[1]}}, {8{m_w_strb[0]}}};
                    m_regs[idx] = (m_regs[idx] & ~mask) | (m_w_data & mask);
                    m_bresp = OKAY;
                    m_pulse = 4'(1 << idx);
                end else begin
                    m_bresp = SLVERR;
                end
                m_aw_held = 0; m_w_held = 0; m_b_pend = 1;
            end
            m_ready_on = 1;
        end
    end

    // Compare every DUT output against the model once per cycle.
    always @(negedge ACLK) begin
        if (ARESETN) begin
            checkOutput("awready", s_axi_awready, m_ready_on && !m_aw_held && !m_b_pend);
            checkOutput("wready", s_axi_wready, m_ready_on && !m_w_held && !m_b_pend);
            checkOutput("arready", s_axi_arready, m_ready_on && !m_r_pend);
            checkOutput("bvalid", s_axi_bvalid, m_b_pend);
            checkOutput("rvalid", s_axi_rvalid, m_r_pend);
            checkOutput("wr_pulse", wr_pulse, m_pulse);
            checkOutput("reg_out", reg_out, {32'h0, m_regs[2], m_regs[1], m_regs[0]});
            if (m_b_pend) checkOutput("bresp", s_axi_bresp, m_bresp);
            if (m_r_pend) begin
                checkOutput("rdata", s_axi_rdata, m_rdata);
                checkOutput("rresp", s_axi_rresp, m_rresp);
            end
        end
    end

    // Channel drivers: raise valid at a falling edge and hold it until the
    // ready seen during that cycle shows the handshake took place.
    task automatic aw_send(input logic [7:0] a);
        bit rdy, done;
        done = 0;
        s_axi_awaddr = a; s_axi_awvalid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            rdy = s_axi_awready;
            @(negedge ACLK);
            if (rdy) begin done = 1; break; end
        end
        s_axi_awvalid = 1'b0;
        if (!done) report_timeout("aw_handshake");
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s);
        bit rdy, done;
        done = 0;
        s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            rdy = s_axi_wready;
            @(negedge ACLK);
            if (rdy) begin done = 1; break; end
        end
        s_axi_wvalid = 1'b0;
        if (!done) report_timeout("w_handshake");
    endtask

    task automatic ar_send(input logic [7:0] a);
        bit rdy, done;
        done = 0;
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            rdy = s_axi_arready;
            @(negedge ACLK);
            if (rdy) begin done = 1; break; end
        end
        s_axi_arvalid = 1'b0;
        if (!done) report_timeout("ar_handshake");
    endtask

    // Directed write with literal response and one-cycle response latency.
    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input logic [1:0] exp_resp,
                            input string name);
        int waited;
        bit got;
        fork
            begin repeat (aw_dly) @(negedge ACLK); aw_send(a); end
            begin repeat (w_dly) @(negedge ACLK); w_send(d, s); end
        join
        got = 0; waited = 0;
        for (int i = 0; i < 50; i++) begin
            if (s_axi_bvalid) begin got = 1; break; end
            waited++;
            @(negedge ACLK);
        end
        if (got) begin
            checkOutput({name, "_b_latency"}, waited, 0);
            checkOutput({name, "_bresp"}, s_axi_bresp, exp_resp);
        end else begin
            report_timeout({name, "_bvalid"});
        end
    endtask

    // Directed read with literal data/response and one-cycle latency.
    task automatic do_read(input logic [7:0] a, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input string name);
        int waited;
        bit got;
        ar_send(a);
        got = 0; waited = 0;
        for (int i = 0; i < 50; i++) begin
            if (s_axi_rvalid) begin got = 1; break; end
            waited++;
            @(negedge ACLK);
        end
        if (got) begin
            checkOutput({name, "_r_latency"}, waited, 0);
            checkOutput({name, "_rdata"}, s_axi_rdata, exp_data);
            checkOutput({name, "_rresp"}, s_axi_rresp, exp_resp);
        end else begin
            report_timeout({name, "_rvalid"});
        end
    endtask

    function automatic logic [7:0] rand_addr();
        if ($urandom_range(0, 9) < 8) return 8'($urandom_range(0, 19));
        return 8'($urandom);
    endfunction

    // Randomized traffic on all channels at once, with random back-pressure
    // on B and R and a status word that changes now and then.
    task automatic applyStimulus(input int n_wr, input int n_rd);
        rand_done = 0;
        fork
            begin
                fork
                    begin
                        for (int i = 0; i < n_wr; i++) begin
                            repeat ($urandom_range(0, 3)) @(negedge ACLK);
                            aw_send(rand_addr());
                        end
                    end
                    begin
                        for (int i = 0; i < n_wr; i++) begin
                            repeat ($urandom_range(0, 3)) @(negedge ACLK);
                            w_send($urandom, 4'($urandom));
                        end
                    end
                    begin
                        for (int i = 0; i < n_rd; i++) begin
                            repeat ($urandom_range(0, 3)) @(negedge ACLK);
                            ar_send(rand_addr());
                        end
                    end
                join
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    s_axi_bready = 1'($urandom_range(0, 1));
                    s_axi_rready = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 7) == 0) status_in = $urandom;
                    @(negedge ACLK);
                end
            end
        join
        s_axi_bready = 1'b1;
        s_axi_rready = 1'b1;
        repeat (4) @(negedge ACLK);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios first, then random traffic, then the hold/reset case.
    initial begin
        #2;
        checkOutput("reset_ctrl", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                                   s_axi_rvalid, wr_pulse, s_axi_bresp, s_axi_rresp}, '0);
        checkOutput("reset_regs", reg_out, '0);
        checkOutput("reset_rdata", s_axi_rdata, '0);
        status_in    = 32'hDEADBEEF;
        s_axi_bready = 1'b1;
        s_axi_rready = 1'b1;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        checkOutput("ready_after_release", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

        do_write(8'h00, 32'd1, 4'hF, 0, 0, OKAY, "wr_r0");
        do_write(8'h04, 32'd2, 4'hF, 0, 1, OKAY, "wr_r1");
        do_write(8'h08, 32'd3, 4'hF, 2, 0, OKAY, "wr_r2");
        do_write(8'h0C, 32'd0, 4'hF, 0, 0, SLVERR, "wr_ro");
        checkOutput("ro_unchanged", reg_out[127:96], 32'h0);
        do_read(8'h00, 32'd1, OKAY, "rd_r0");
        do_read(8'h04, 32'd2, OKAY, "rd_r1");
        do_read(8'h08, 32'd3, OKAY, "rd_r2");
        do_read(8'h0B, 32'd3, OKAY, "rd_r2_offset");
        do_read(8'h0C, 32'hDEADBEEF, OKAY, "rd_status");
        do_read(8'h10, 32'h0, SLVERR, "rd_oor");

        do_write(8'h04, 32'hA5A5A5A5, 4'hF, 3, 0, OKAY, "wr_w_first");
        checkOutput("reg1_w_first", reg_out[63:32], 32'hA5A5A5A5);

        do_write(8'h00, 32'hFFFFFFFF, 4'hF, 0, 0, OKAY, "wr_preload");
        do_write(8'h00, 32'h12345678, 4'b0101, 0, 0, OKAY, "wr_strb");
        checkOutput("reg0_strb", reg_out[31:0], 32'hFF34FF78);
        do_write(8'h02, 32'h0, 4'b0000, 0, 0, OKAY, "wr_nostrb");
        do_read(8'h00, 32'hFF34FF78, OKAY, "rd_strb");
        do_write(8'h40, 32'h12345678, 4'hF, 0, 0, SLVERR, "wr_oor");

        applyStimulus(60, 60);

        s_axi_bready = 1'b0;
        s_axi_rready = 1'b0;
        do_write(8'h00, 32'hCAFEF00D, 4'hF, 0, 0, OKAY, "wr_hold");
        do_read(8'h00, 32'hCAFEF00D, OKAY, "rd_hold");
        repeat (5) begin
            @(negedge ACLK);
            checkOutput("hold_flags", {s_axi_bvalid, s_axi_rvalid, s_axi_awready,
                                       s_axi_wready, s_axi_arready}, 5'b11000);
            checkOutput("hold_rdata", s_axi_rdata, 32'hCAFEF00D);
            checkOutput("hold_bresp", s_axi_bresp, OKAY);
        end
        #2;
        ARESETN = 1'b0;
        #1;
        checkOutput("async_reset_ctrl", {s_axi_bvalid, s_axi_rvalid, s_axi_awready, s_axi_wready,
                                         s_axi_arready, wr_pulse}, '0);
        checkOutput("async_reset_regs", reg_out, '0);
        checkOutput("async_reset_rdata", s_axi_rdata, '0);
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        s_axi_bready = 1'b1;
        s_axi_rready = 1'b1;
        do_read(8'h00, 32'h0, OKAY, "rd_post_reset0");
        do_read(8'h04, 32'h0, OKAY, "rd_post_reset1");
        do_read(8'h08, 32'h0, OKAY, "rd_post_reset2");
        repeat (2) @(negedge ACLK);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
